// File: rtl/alu_exec_unit.sv
// alu_exec_unit: RV32I integer execution stage for one RS ALU issue port.
// Define ALU_MUL_EN to build in the iterative 32-cycle shift-add MUL path.
//
// state   | meaning
// IDLE    | accepting issues; single-cycle ops write back on the next edge
// MUL_RUN | shift-add multiply in flight, fu_ready low (ALU_MUL_EN only)

`ifndef RS_WIDTH
`define RS_WIDTH   120
`define RS_OPCODE  119:113
`define RS_FUNCT3  112:110
`define RS_CSIGS   109:108
`define RS_RD      107:102
`define RS_DATA1   101:70
`define RS_DATA2   69:38
`define RS_IMM     37:6
`define RS_ROB     5:0
`endif

`ifndef ALU_WIDTH
`define ALU_WIDTH  39
`define ALU_READY  38
`define ALU_REG    37:32
`define ALU_RESULT 31:0
`endif

module alu_exec_unit #(
  parameter int PREG_WIDTH = 6,
  parameter int ROB_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [`RS_WIDTH-1:0]  instr_in,
  input  logic                  instr_valid,
  output logic                  fu_ready,
  output logic [`ALU_WIDTH-1:0] wb_out,
  output logic [ROB_WIDTH-1:0]  wb_rob,
  output logic                  protocol_err
);

  localparam logic [6:0] OP_REG = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  logic [6:0]            opcode;
  logic [2:0]            funct3;
  logic [1:0]            c_sigs;
  logic [PREG_WIDTH-1:0] rd;
  logic [31:0]           data1;
  logic [31:0]           data2;
  logic [31:0]           imm;
  logic [ROB_WIDTH-1:0]  rob_num;

  assign opcode  = instr_in[`RS_OPCODE];
  assign funct3  = instr_in[`RS_FUNCT3];
  assign c_sigs  = instr_in[`RS_CSIGS];
  assign rd      = instr_in[`RS_RD];
  assign data1   = instr_in[`RS_DATA1];
  assign data2   = instr_in[`RS_DATA2];
  assign imm     = instr_in[`RS_IMM];
  assign rob_num = instr_in[`RS_ROB];

  logic [31:0]        op_b;
  logic [4:0]         shamt;
  logic signed [31:0] data1_s;
  logic signed [31:0] sra_res;
  logic [31:0]        alu_res;

  assign op_b    = (opcode == OP_IMM) ? imm : data2;
  assign shamt   = op_b[4:0];
  assign data1_s = data1;
  // kept in its own signed assignment so the arithmetic shift is not demoted
  assign sra_res = data1_s >>> shamt;

  always_comb begin
    alu_res = '0;
    if (opcode == OP_LUI) begin
      alu_res = imm;
    end else if (opcode == OP_REG || opcode == OP_IMM) begin
      unique case (funct3)
        3'b000: alu_res = (c_sigs[0] && opcode == OP_REG) ? data1 - op_b : data1 + op_b;
        3'b001: alu_res = data1 << shamt;
        3'b010: alu_res = {31'b0, ($signed(data1) < $signed(op_b))};
        3'b011: alu_res = {31'b0, (data1 < op_b)};
        3'b100: alu_res = data1 ^ op_b;
        3'b101: alu_res = c_sigs[0] ? sra_res : data1 >> shamt;
        3'b110: alu_res = data1 | op_b;
        3'b111: alu_res = data1 & op_b;
      endcase
    end
  end

  logic                  wb_ready;
  logic [PREG_WIDTH-1:0] wb_reg;
  logic [31:0]           wb_result;

  assign wb_out = {wb_ready, wb_reg, wb_result};

`ifdef ALU_MUL_EN
  typedef enum logic {IDLE = 1'b0, MUL_RUN = 1'b1} state_t;

  state_t                state;
  logic [4:0]            mul_cnt;
  logic [31:0]           mcand;
  logic [31:0]           mplier;
  logic [31:0]           acc;
  logic [31:0]           acc_next;
  logic [PREG_WIDTH-1:0] mul_rd;
  logic [ROB_WIDTH-1:0]  mul_rob;
  logic                  is_mul;

  assign is_mul   = (opcode == OP_REG) && c_sigs[1] && (funct3 == 3'b000);
  assign acc_next = acc + (mplier[0] ? mcand : 32'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      fu_ready     <= 1'b1;
      wb_ready     <= 1'b0;
      wb_reg       <= '0;
      wb_result    <= '0;
      wb_rob       <= '0;
      protocol_err <= 1'b0;
      mul_cnt      <= '0;
      mcand        <= '0;
      mplier       <= '0;
      acc          <= '0;
      mul_rd       <= '0;
      mul_rob      <= '0;
    end else begin
      wb_ready <= 1'b0;
      if (instr_valid && !fu_ready)
        protocol_err <= 1'b1;
      case (state)
        IDLE: begin
          if (instr_valid) begin
            if (is_mul) begin
              state    <= MUL_RUN;
              fu_ready <= 1'b0;
              mcand    <= data1;
              mplier   <= data2;
              acc      <= '0;
              mul_cnt  <= 5'd31;
              mul_rd   <= rd;
              mul_rob  <= rob_num;
            end else begin
              wb_ready  <= 1'b1;
              wb_reg    <= rd;
              wb_result <= alu_res;
              wb_rob    <= rob_num;
            end
          end
        end
        MUL_RUN: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          // terminal count: the 32nd iteration retires the product
          if (mul_cnt == 5'd0) begin
            state     <= IDLE;
            fu_ready  <= 1'b1;
            wb_ready  <= 1'b1;
            wb_reg    <= mul_rd;
            wb_result <= acc_next;
            wb_rob    <= mul_rob;
          end else begin
            mul_cnt <= mul_cnt - 5'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`else
  logic unused_csig;
  assign unused_csig = c_sigs[1];
  assign fu_ready    = 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_ready     <= 1'b0;
      wb_reg       <= '0;
      wb_result    <= '0;
      wb_rob       <= '0;
      protocol_err <= 1'b0;
    end else begin
      wb_ready <= 1'b0;
      if (instr_valid && !fu_ready)
        protocol_err <= 1'b1;
      if (instr_valid) begin
        wb_ready  <= 1'b1;
        wb_reg    <= rd;
        wb_result <= alu_res;
        wb_rob    <= rob_num;
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: random + directed stimulus against a behavioural model of alu_exec_unit.
// Builds with or without ALU_MUL_EN, matching the DUT build.
module tb_alu_exec_unit;

  localparam logic [6:0] OP_REG   = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
`ifdef ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [119:0] instr_in = '0;
  logic         instr_valid = 1'b0;
  logic         fu_ready;
  logic [38:0]  wb_out;
  logic [5:0]   wb_rob;
  logic         protocol_err;

  int checks = 0;
  int errors = 0;

  alu_exec_unit #(.PREG_WIDTH(6), .ROB_WIDTH(6)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instr_in     (instr_in),
    .instr_valid  (instr_valid),
    .fu_ready     (fu_ready),
    .wb_out       (wb_out),
    .wb_rob       (wb_rob),
    .protocol_err (protocol_err)
  );

  always #5 clk = ~clk;

  // model state: what the outputs must be after the most recent edge
  logic        exp_ready;
  logic [5:0]  exp_reg;
  logic [31:0] exp_res;
  logic [5:0]  exp_rob;
  logic        exp_fu_ready;
  logic        exp_perr;
  int          mul_left;
  logic [31:0] mul_res;
  logic [5:0]  mul_rd;
  logic [5:0]  mul_rob;

  function automatic logic [119:0] mk(input logic [6:0] op, input logic [2:0] f3,
                                      input logic [1:0] cs, input logic [5:0] rd,
                                      input logic [31:0] d1, input logic [31:0] d2,
                                      input logic [31:0] im, input logic [5:0] rob);
    return {op, f3, cs, rd, d1, d2, im, rob};
  endfunction

  function automatic logic [31:0] ref_alu(input logic [119:0] ins);
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        alt;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ones;
    logic [31:0] fill;
    int          s;
    op  = ins[119:113];
    f3  = ins[112:110];
    alt = ins[108];
    a   = ins[101:70];
    b   = (op == OP_IMM) ? ins[37:6] : ins[69:38];
    s   = int'(b[4:0]);
    ones = 32'hFFFF_FFFF;
    fill = a[31] ? ~(ones >> s) : 32'd0;
    if (op == OP_LUI) return ins[37:6];
    if (op != OP_REG && op != OP_IMM) return 32'd0;
    case (f3)
      3'd0:    return (alt && op == OP_REG) ? a - b : a + b;
      3'd1:    return a << s;
      3'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3:    return (a < b) ? 32'd1 : 32'd0;
      3'd4:    return a ^ b;
      3'd5:    return alt ? ((a >> s) | fill) : (a >> s);
      3'd6:    return a | b;
      default: return a & b;
    endcase
  endfunction

  task automatic model_reset();
    exp_ready    = 1'b0;
    exp_reg      = '0;
    exp_res      = '0;
    exp_rob      = '0;
    exp_fu_ready = 1'b1;
    exp_perr     = 1'b0;
    mul_left     = 0;
  endtask

  task automatic model_edge(input logic v, input logic [119:0] ins);
    logic [63:0] prod;
    exp_ready = 1'b0;
    if (v && !exp_fu_ready) exp_perr = 1'b1;
    if (mul_left > 0) begin
      mul_left = mul_left - 1;
      if (mul_left == 0) begin
        exp_ready    = 1'b1;
        exp_reg      = mul_rd;
        exp_res      = mul_res;
        exp_rob      = mul_rob;
        exp_fu_ready = 1'b1;
      end
    end else if (v) begin
      if (MUL_EN && ins[119:113] == OP_REG && ins[109] && ins[112:110] == 3'd0) begin
        prod         = {32'd0, ins[101:70]} * {32'd0, ins[69:38]};
        mul_res      = prod[31:0];
        mul_rd       = ins[107:102];
        mul_rob      = ins[5:0];
        mul_left     = 32;
        exp_fu_ready = 1'b0;
      end else begin
        exp_ready = 1'b1;
        exp_reg   = ins[107:102];
        exp_res   = ref_alu(ins);
        exp_rob   = ins[5:0];
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h t=%0t", name, got, want, $time);
    end
  endtask

  task automatic compare();
    chk("wb_ready", 32'(wb_out[38]), 32'(exp_ready));
    chk("fu_ready", 32'(fu_ready), 32'(exp_fu_ready));
    chk("protocol_err", 32'(protocol_err), 32'(exp_perr));
    if (exp_ready) begin
      chk("wb_reg", 32'(wb_out[37:32]), 32'(exp_reg));
      chk("wb_result", wb_out[31:0], exp_res);
      chk("wb_rob", 32'(wb_rob), 32'(exp_rob));
    end
  endtask

  // called at a negedge; leaves the bench at the next negedge with outputs checked
  task automatic step(input logic v, input logic [119:0] ins);
    instr_valid = v;
    instr_in    = ins;
    @(posedge clk);
    model_edge(v, ins);
    @(negedge clk);
    compare();
    instr_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0);
  endtask

  task automatic async_reset_check(input string tag);
    #2 rst_n = 1'b0;
    #1;
    chk({tag, "_rst_fu_ready"}, 32'(fu_ready), 32'd1);
    chk({tag, "_rst_wb_out"}, wb_out[31:0] | {25'd0, wb_out[38:32]}, 32'd0);
    chk({tag, "_rst_wb_rob"}, 32'(wb_rob), 32'd0);
    chk({tag, "_rst_perr"}, 32'(protocol_err), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [119:0] ins;
    logic [6:0]   op;
    logic [6:0]   ops [5];
    int           low_cnt;
    ops[0] = OP_REG; ops[1] = OP_IMM; ops[2] = OP_LUI; ops[3] = OP_AUIPC; ops[4] = 7'h00;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    compare();

    // ADD wrapping modulo 2^32
    step(1'b1, mk(OP_REG, 3'd0, 2'b00, 6'd5, 32'd7, 32'hFFFF_FFFE, 32'd0, 6'd9));
    chk("add_lit_res", wb_out[31:0], 32'd5);
    chk("add_lit_reg", 32'(wb_out[37:32]), 32'd5);
    chk("add_lit_rob", 32'(wb_rob), 32'd9);
    idle(1);
    chk("add_lit_drop", 32'(wb_out[38]), 32'd0);

    step(1'b1, mk(OP_IMM, 3'd5, 2'b01, 6'd1, 32'h8000_0000, 32'd0, 32'd4, 6'd2));
    chk("srai_lit", wb_out[31:0], 32'hF800_0000);
    step(1'b1, mk(OP_IMM, 3'd5, 2'b00, 6'd1, 32'h8000_0000, 32'd0, 32'd4, 6'd3));
    chk("srli_lit", wb_out[31:0], 32'h0800_0000);
    step(1'b1, mk(OP_REG, 3'd2, 2'b00, 6'd1, 32'hFFFF_FFFF, 32'd1, 32'd0, 6'd4));
    chk("slt_lit", wb_out[31:0], 32'd1);
    step(1'b1, mk(OP_REG, 3'd3, 2'b00, 6'd1, 32'hFFFF_FFFF, 32'd1, 32'd0, 6'd5));
    chk("sltu_lit", wb_out[31:0], 32'd0);
    step(1'b1, mk(OP_REG, 3'd0, 2'b01, 6'd0, 32'd3, 32'd5, 32'd0, 6'd6));
    chk("sub_lit", wb_out[31:0], 32'hFFFF_FFFE);
    chk("rd0_lit", 32'(wb_out[38]), 32'd1);
    step(1'b1, mk(OP_LUI, 3'd0, 2'b00, 6'd7, 32'd1, 32'd2, 32'h1234_5000, 6'd7));
    chk("lui_lit", wb_out[31:0], 32'h1234_5000);
    step(1'b1, mk(OP_AUIPC, 3'd0, 2'b00, 6'd8, 32'd1, 32'd2, 32'h1234_5000, 6'd8));
    chk("auipc_lit", wb_out[31:0], 32'd0);
    chk("auipc_ready", 32'(wb_out[38]), 32'd1);

    // back-to-back ADD then XOR
    step(1'b1, mk(OP_REG, 3'd0, 2'b00, 6'd3, 32'd10, 32'd20, 32'd0, 6'd11));
    chk("b2b_add_reg", 32'(wb_out[37:32]), 32'd3);
    chk("b2b_add_res", wb_out[31:0], 32'd30);
    step(1'b1, mk(OP_REG, 3'd4, 2'b00, 6'd4, 32'hF0F0_0000, 32'h0FF0_0000, 32'd0, 6'd12));
    chk("b2b_xor_ready", 32'(wb_out[38]), 32'd1);
    chk("b2b_xor_reg", 32'(wb_out[37:32]), 32'd4);
    chk("b2b_xor_rob", 32'(wb_rob), 32'd12);
    chk("b2b_xor_res", wb_out[31:0], 32'hFF00_0000);
    idle(1);

`ifdef ALU_MUL_EN
    step(1'b1, mk(OP_REG, 3'd0, 2'b10, 6'd9, 32'h0001_0000, 32'h0001_0001, 32'd0, 6'd20));
    low_cnt = 0;
    for (int k = 1; k <= 40 && !wb_out[38]; k++) begin
      if (!fu_ready) low_cnt++;
      step(1'b0, '0);
      if (wb_out[38]) chk("mul_latency", 32'(k), 32'd32);
    end
    chk("mul_low_cycles", 32'(low_cnt), 32'd32);
    chk("mul_lit_res", wb_out[31:0], 32'h0001_0000);
    chk("mul_lit_rob", 32'(wb_rob), 32'd20);
    chk("mul_fu_back", 32'(fu_ready), 32'd1);
`else
    step(1'b1, mk(OP_REG, 3'd0, 2'b10, 6'd9, 32'd3, 32'd4, 32'd0, 6'd20));
    chk("mulenc_as_add", wb_out[31:0], 32'd7);
    step(1'b1, mk(OP_REG, 3'd0, 2'b11, 6'd9, 32'd3, 32'd4, 32'd0, 6'd21));
    chk("mulenc_as_sub", wb_out[31:0], 32'hFFFF_FFFF);
`endif

    // randomized traffic, issuing only when the model says the unit is free
    for (int i = 0; i < 400; i++) begin
      op  = ops[$urandom_range(0, 4)];
      ins = mk(op, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 6'($urandom),
               $urandom, ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom,
               $urandom, 6'($urandom));
      step(exp_fu_ready && ($urandom_range(0, 3) != 0), ins);
    end
    idle(35);

`ifdef ALU_MUL_EN
    // issue while busy: dropped, sticky error, product unaffected
    step(1'b1, mk(OP_REG, 3'd0, 2'b10, 6'd10, 32'd12345, 32'd678, 32'd0, 6'd30));
    idle(3);
    step(1'b1, mk(OP_REG, 3'd0, 2'b00, 6'd11, 32'd1, 32'd1, 32'd0, 6'd31));
    chk("perr_set", 32'(protocol_err), 32'd1);
    chk("perr_no_wb", 32'(wb_out[38]), 32'd0);
    for (int k = 0; k < 40 && !wb_out[38]; k++) step(1'b0, '0);
    chk("perr_mul_res", wb_out[31:0], 32'd8369910);
    chk("perr_mul_rob", 32'(wb_rob), 32'd30);
    idle(2);
    chk("perr_sticky", 32'(protocol_err), 32'd1);

    // reset mid-multiply: no writeback afterwards
    step(1'b1, mk(OP_REG, 3'd0, 2'b10, 6'd12, 32'd5, 32'd6, 32'd0, 6'd32));
    idle(5);
    async_reset_check("mulabort");
    idle(36);
`endif

    step(1'b1, mk(OP_IMM, 3'd6, 2'b00, 6'd13, 32'h00FF_0000, 32'd0, 32'h0000_00FF, 6'd33));
    async_reset_check("final");
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Execution stage behind the reservation station's ALU issue ports (FU 0 / FU 1; one instance per port). Accepts one issued `RS_WIDTH` entry per cycle, executes integer RV32I register/immediate ops in one cycle and, optionally, MUL in an iterative multi-cycle sequence. Returns a one-cycle `ALU_WIDTH` writeback bus that feeds the RS wakeup inputs (alu0_in/alu1_in). Reports its busy state for the FU table bit it owns.

## Interface
- PREG_WIDTH, 6, physical register tag width; must match `ALU_REG` field width.
- ROB_WIDTH, 6, ROB index width.
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- instr_in  in  `RS_WIDTH  issued RS entry; fields decoded with `RS_*` macros (opcode, funct3, c_sigs, rd, data1, data2, imm, rob_num).
- instr_valid  in  1  issue strobe for this FU, qualifies instr_in.
- fu_ready  out  1  1 = unit accepts an issue this cycle; drives this unit's fu_table bit.
- wb_out  out  `ALU_WIDTH  writeback: `ALU_READY`, `ALU_REG` (= rd), `ALU_RESULT`.
- wb_rob  out  ROB_WIDTH  rob_num of the instruction in wb_out.
- protocol_err  out  1  sticky; set when instr_valid arrives while fu_ready = 0.

## Operation
- States: IDLE, MUL_RUN (MUL_RUN exists only with ALU_MUL_EN).
- IDLE, instr_valid = 1, non-MUL op: compute and register result; wb_out[`ALU_READY`] = 1 the next cycle for exactly one cycle; stay IDLE.
- Operand B: data2 for opcode 0110011; imm for 0010011; LUI (0110111) result = imm; AUIPC/others unsupported -> result 0, still written back.
- funct3 decode: 000 ADD/SUB, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL/SRA, 110 OR, 111 AND. c_sigs[0] = alt: SUB for 000 (R-type only), SRA for 101.
- Shift amount = operand B[4:0]. All arithmetic modulo 2^32, no overflow flag.
- MUL (opcode 0110011, c_sigs[1] = 1, funct3 000): latch operands, enter MUL_RUN, fu_ready = 0; 32 shift-add iterations, one per cycle, low 32 bits of product kept; on last iteration register result, pulse wb_out, return to IDLE.
- wb_out[`ALU_READY`] = 0 on every cycle without a completion; `ALU_REG`/`ALU_RESULT` hold last value (don't-care when not ready).
- instr_valid while busy: instruction dropped, protocol_err set, in-flight MUL unaffected.
- rd = 0 tag is written back like any other; suppression is the RS/rename's job.

## Timing
- Reset (async assert): state IDLE, fu_ready = 1, wb_out = 0, wb_rob = 0, protocol_err = 0, MUL counter = 0. Reset mid-MUL aborts with no writeback.
- Single-cycle op: issue at edge N -> wb_out valid during cycle N..N+1 (registered at edge N), i.e. visible to the RS negedge wakeup in the same cycle it appears.
- fu_ready is registered: falls at the edge that accepts MUL, rises at the edge that produces the MUL writeback; new issue accepted that same edge only if fu_ready was already 1 (no same-cycle reuse).
- MUL latency: issue edge N -> writeback registered at edge N+32.
- Back-to-back single-cycle ops: one per cycle, each writeback one cycle wide, no bubble.

## Configuration
- ALU_MUL_EN defined: MUL_RUN state, multiplier datapath and counter compiled in as above.
- ALU_MUL_EN undefined: c_sigs[1] ignored, MUL encodings execute as ADD/SUB single-cycle, fu_ready tied to 1, protocol_err never sets.

## Test plan
- Reset: rst_n low mid-cycle -> fu_ready = 1, wb_out = 0, protocol_err = 0 immediately, no clock needed.
- ADD rd = 5, data1 = 7, data2 = 0xFFFFFFFE -> next cycle ALU_READY = 1, ALU_REG = 5, ALU_RESULT = 5, wb_rob = issued rob_num; following cycle ALU_READY = 0.
- SRA alt: data1 = 0x80000000, imm = 4, funct3 101, c_sigs[0] = 1 -> 0xF8000000; same with c_sigs[0] = 0 -> 0x08000000; SLT(-1, 1) = 1, SLTU(-1, 1) = 0.
- Back-to-back: ADD then XOR on consecutive cycles -> two consecutive one-cycle writebacks with correct tags.
- ALU_MUL_EN: MUL 0x10000 × 0x10001 -> fu_ready low for 32 cycles, writeback 0x00010000 (low 32 bits of 0x100010000) at edge N+32.
- ALU_MUL_EN: issue ADD during MUL_RUN -> dropped, protocol_err = 1 and stays 1, MUL result still correct.
